glitch_sequencer: RTL and testbench

Timing controller behind the glitch pulse output. It latches a glitch configuration when armed, can optionally hold the target in reset first, and then waits for a synchronized trigger edge. After a programmable delay it emits a train of N pulses with programmable width and gap. The UART command decoder drives it, and its outputs go directly to the pulse and target-reset pins.

---
 rtl/glitch_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: latches a shot config on arm, optionally holds the target in reset,
// waits for a synchronized trigger edge, then emits a delayed train of glitch pulses.
module glitch_sequencer #(
    parameter int unsigned DELAY_W      = 32,
    parameter int unsigned WIDTH_W      = 16,
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned RESET_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger_i,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic [WIDTH_W-1:0] cfg_width_i,
    input  logic [WIDTH_W-1:0] cfg_gap_i,
    input  logic [COUNT_W-1:0] cfg_count_i,
    input  logic               cfg_edge_i,
    input  logic               cfg_reset_en_i,
    input  logic               arm_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pulse_o,
    output logic               target_reset_o,
    output logic [2:0]         state_o
);

    localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RstW-1:0] RstLoad = RstW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitTrig = 3'd2,
        StDelay    = 3'd3,
        StPulse    = 3'd4,
        StGap      = 3'd5
    } state_e;

    state_e             state;
    logic               sync1, sync2, sync3;
    logic               edge_evt;
    logic [DELAY_W-1:0] sh_delay;
    logic [WIDTH_W-1:0] sh_width, sh_gap;
    logic [COUNT_W-1:0] sh_count;
    logic               sh_edge;
    logic [DELAY_W-1:0] delay_cnt;
    logic [WIDTH_W-1:0] width_cnt;
    logic [COUNT_W-1:0] pulse_cnt;
    logic [RstW-1:0]    rst_cnt;
    logic [WIDTH_W-1:0] width_load, gap_load;
    logic [COUNT_W-1:0] count_load;

    // Trigger synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= trigger_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_evt = sh_edge ? (sync3 & ~sync2) : (sync2 & ~sync3);

    // Counter reload values: counters run down to zero, and a zero config means one cycle.
    always_comb begin
        width_load = (sh_width == '0) ? '0 : sh_width - WIDTH_W'(1);
        gap_load   = (sh_gap == '0) ? '0 : sh_gap - WIDTH_W'(1);
        count_load = (sh_count == '0) ? '0 : sh_count - COUNT_W'(1);
    end

    // Shot sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            sh_delay       <= '0;
            sh_width       <= '0;
            sh_gap         <= '0;
            sh_count       <= '0;
            sh_edge        <= 1'b0;
            delay_cnt      <= '0;
            width_cnt      <= '0;
            pulse_cnt      <= '0;
            rst_cnt        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pulse_o        <= 1'b0;
            target_reset_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state != StIdle && abort_i) begin
                state          <= StIdle;
                busy_o         <= 1'b0;
                pulse_o        <= 1'b0;
                target_reset_o <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (arm_i && !abort_i) begin
                            sh_delay <= cfg_delay_i;
                            sh_width <= cfg_width_i;
                            sh_gap   <= cfg_gap_i;
                            sh_count <= cfg_count_i;
                            sh_edge  <= cfg_edge_i;
                            busy_o   <= 1'b1;
                            if (cfg_reset_en_i) begin
                                state          <= StReset;
                                target_reset_o <= 1'b1;
                                rst_cnt        <= RstLoad;
                            end else begin
                                state <= StWaitTrig;
                            end
                        end
                    end
                    StReset: begin
                        if (rst_cnt == '0) begin
                            target_reset_o <= 1'b0;
                            state          <= StWaitTrig;
                        end else begin
                            rst_cnt <= rst_cnt - RstW'(1);
                        end
                    end
                    StWaitTrig: begin
                        if (edge_evt) begin
                            pulse_cnt <= count_load;
                            if (sh_delay == '0) begin
                                state     <= StPulse;
                                pulse_o   <= 1'b1;
                                width_cnt <= width_load;
                            end else begin
                                state     <= StDelay;
                                delay_cnt <= sh_delay - DELAY_W'(1);
                            end
                        end
                    end
                    StDelay: begin
                        if (delay_cnt == '0) begin
                            state     <= StPulse;
                            pulse_o   <= 1'b1;
                            width_cnt <= width_load;
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_W'(1);
                        end
                    end
                    StPulse: begin
                        if (width_cnt == '0) begin
                            pulse_o <= 1'b0;
                            if (pulse_cnt == '0) begin
                                state  <= StIdle;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                pulse_cnt <= pulse_cnt - COUNT_W'(1);
                                width_cnt <= gap_load;
                                state     <= StGap;
                            end
                        end else begin
                            width_cnt <= width_cnt - WIDTH_W'(1);
                        end
                    end
                    StGap: begin
                        if (width_cnt == '0) begin
                            state     <= StPulse;
                            pulse_o   <= 1'b1;
                            width_cnt <= width_load;
                        end else begin
                            width_cnt <= width_cnt - WIDTH_W'(1);
                        end
                    end
                    default: begin
                        state          <= StIdle;
                        busy_o         <= 1'b0;
                        pulse_o        <= 1'b0;
                        target_reset_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Testbench for glitch_sequencer: table-driven shots checked cycle by cycle through an
// expected-value queue, plus hand-written abort, reset and config-shadowing sequences.
module tb_glitch_sequencer;

    typedef struct packed {
        logic pulse;
        logic done;
        logic busy;
    } exp_t;

    typedef struct {
        int   d;
        int   w;
        int   g;
        int   n;
        logic edge_sel;
        int   exp_rises;
        int   exp_first;
        int   exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [31:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_gap;
    logic [7:0]  cfg_count;
    logic        cfg_edge;
    logic        cfg_reset_en;
    logic        arm;
    logic        abort;
    logic        busy;
    logic        done;
    logic        pulse;
    logic        target_reset;
    logic [2:0]  state;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    glitch_sequencer #(
        .DELAY_W(32),
        .WIDTH_W(16),
        .COUNT_W(8),
        .RESET_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger_i(trigger),
        .cfg_delay_i(cfg_delay),
        .cfg_width_i(cfg_width),
        .cfg_gap_i(cfg_gap),
        .cfg_count_i(cfg_count),
        .cfg_edge_i(cfg_edge),
        .cfg_reset_en_i(cfg_reset_en),
        .arm_i(arm),
        .abort_i(abort),
        .busy_o(busy),
        .done_o(done),
        .pulse_o(pulse),
        .target_reset_o(target_reset),
        .state_o(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs k edges after the trigger is first sampled.
    function automatic exp_t model(int k, int d, int w, int g, int n);
        exp_t m;
        int we, ge, ne, start, fin, s;
        we    = (w == 0) ? 1 : w;
        ge    = (g == 0) ? 1 : g;
        ne    = (n == 0) ? 1 : n;
        start = 2 + d;
        fin   = start + (ne - 1) * (we + ge) + we;
        m.pulse = 1'b0;
        for (int i = 0; i < ne; i++) begin
            s = start + i * (we + ge);
            if (k >= s && k < s + we) m.pulse = 1'b1;
        end
        m.done = (k == fin);
        m.busy = (k < fin);
        return m;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic arm_shot(input int d, input int w, input int g, input int n,
                            input logic e, input logic ren);
        cfg_delay    = d;
        cfg_width    = w[15:0];
        cfg_gap      = g[15:0];
        cfg_count    = n[7:0];
        cfg_edge     = e;
        cfg_reset_en = ren;
        arm          = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Called right after the active trigger transition was driven on a falling clock edge.
    task automatic watch_shot(input int d, input int w, input int g, input int n, input int len,
                              output int rises, output int first, output int done_at);
        exp_t e;
        logic prev;
        rises   = 0;
        first   = -1;
        done_at = -1;
        prev    = 1'b0;
        for (int k = 0; k < len; k++) exp_q.push_back(model(k, d, w, g, n));
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("pulse_o k=%0d", k), pulse, e.pulse);
            check($sformatf("done_o k=%0d", k), done, e.done);
            check($sformatf("busy_o k=%0d", k), busy, e.busy);
            if (pulse && !prev) begin
                rises++;
                if (first < 0) first = k;
            end
            if (done && done_at < 0) done_at = k;
            prev = pulse;
        end
    endtask

    initial begin
        int rises, first, done_at, cnt, seen_p, seen_d, seen_b;

        vecs[0] = '{10, 4, 3, 1, 1'b0, 1, 12, 16};
        vecs[1] = '{0, 2, 5, 3, 1'b0, 3, 2, 18};
        vecs[2] = '{0, 0, 0, 0, 1'b1, 1, 2, 3};
        vecs[3] = '{1, 1, 1, 4, 1'b0, 4, 3, 10};
        vecs[4] = '{5, 3, 0, 2, 1'b1, 2, 7, 14};

        rst = 1'b1; trigger = 1'b0; arm = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
        cfg_edge = 1'b0; cfg_reset_en = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset state_o", state, 0);
        check("reset busy_o", busy, 0);
        check("reset done_o", done, 0);
        check("reset pulse_o", pulse, 0);
        check("reset target_reset_o", target_reset, 0);

        // Table-driven shots; each first shows the opposite trigger edge is ignored.
        for (int v = 0; v < 5; v++) begin
            trigger = ~vecs[v].edge_sel;
            wait_cycles(5);
            arm_shot(vecs[v].d, vecs[v].w, vecs[v].g, vecs[v].n, vecs[v].edge_sel, 1'b0);
            trigger = vecs[v].edge_sel;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check($sformatf("v%0d wrong-edge state_o", v), state, 2);
                check($sformatf("v%0d wrong-edge pulse_o", v), pulse, 0);
            end
            trigger = ~vecs[v].edge_sel;
            watch_shot(vecs[v].d, vecs[v].w, vecs[v].g, vecs[v].n, vecs[v].exp_done + 4,
                       rises, first, done_at);
            check($sformatf("v%0d pulse count", v), rises, vecs[v].exp_rises);
            check($sformatf("v%0d first rise", v), first, vecs[v].exp_first);
            check($sformatf("v%0d done edge", v), done_at, vecs[v].exp_done);
            check($sformatf("v%0d end state_o", v), state, 0);
        end

        // Target reset phase with the trigger toggling throughout.
        trigger = 1'b0;
        wait_cycles(5);
        arm_shot(0, 1, 1, 1, 1'b0, 1'b1);
        cnt = 0; seen_p = 0;
        for (int i = 0; i < 1100 && target_reset; i++) begin
            cnt++;
            if (pulse) seen_p++;
            if (cnt >= 990) trigger = 1'b0;
            else if (cnt % 3 == 0) trigger = ~trigger;
            @(negedge clk);
        end
        check("target_reset high cycles", cnt, 1000);
        check("pulses during reset", seen_p, 0);
        check("after reset state_o", state, 2);
        wait_cycles(3);
        check("wait_trig pulse_o", pulse, 0);
        trigger = 1'b1;
        watch_shot(0, 1, 1, 1, 7, rises, first, done_at);
        check("post-reset first rise", first, 2);
        check("post-reset done edge", done_at, 3);

        // Config changes and a second arm while busy must not affect the shot.
        trigger = 1'b0;
        wait_cycles(5);
        arm_shot(3, 4, 1, 1, 1'b0, 1'b0);
        cfg_width = 16'd9; cfg_delay = 0; cfg_count = 8'd5;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        wait_cycles(2);
        check("rearm state_o", state, 2);
        trigger = 1'b1;
        watch_shot(3, 4, 1, 1, 12, rises, first, done_at);
        check("shadow pulse count", rises, 1);
        check("shadow first rise", first, 5);
        check("shadow done edge", done_at, 9);

        // Abort while in DELAY.
        trigger = 1'b0;
        wait_cycles(5);
        arm_shot(20, 3, 1, 1, 1'b0, 1'b0);
        trigger = 1'b1;
        wait_cycles(5);
        check("pre-abort delay state_o", state, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort delay state_o", state, 0);
        check("abort delay busy_o", busy, 0);
        check("abort delay pulse_o", pulse, 0);
        seen_p = 0; seen_d = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pulse) seen_p++;
            if (done) seen_d++;
        end
        check("abort delay later pulses", seen_p, 0);
        check("abort delay done_o", seen_d, 0);

        // Abort in the middle of a pulse.
        trigger = 1'b0;
        wait_cycles(5);
        arm_shot(0, 8, 1, 1, 1'b0, 1'b0);
        trigger = 1'b1;
        wait_cycles(5);
        check("pre-abort pulse_o", pulse, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort pulse pulse_o", pulse, 0);
        check("abort pulse state_o", state, 0);
        check("abort pulse done_o", done, 0);
        seen_p = 0; seen_d = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pulse) seen_p++;
            if (done) seen_d++;
        end
        check("abort pulse later pulses", seen_p, 0);
        check("abort pulse done_o", seen_d, 0);

        // Abort together with arm in IDLE: nothing starts.
        trigger = 1'b0;
        wait_cycles(5);
        abort = 1'b1;
        arm_shot(0, 2, 1, 1, 1'b0, 1'b0);
        abort = 1'b0;
        check("arm+abort busy_o", busy, 0);
        check("arm+abort state_o", state, 0);
        trigger = 1'b1;
        seen_p = 0; seen_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pulse) seen_p++;
            if (busy) seen_b++;
        end
        check("arm+abort pulses", seen_p, 0);
        check("arm+abort busy cycles", seen_b, 0);

        // Synchronous reset in the middle of a pulse.
        trigger = 1'b0;
        wait_cycles(5);
        arm_shot(0, 50, 1, 1, 1'b0, 1'b0);
        trigger = 1'b1;
        wait_cycles(5);
        check("pre-rst pulse_o", pulse, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-shot rst pulse_o", pulse, 0);
        check("mid-shot rst busy_o", busy, 0);
        check("mid-shot rst state_o", state, 0);
        check("mid-shot rst target_reset_o", target_reset, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
